key_conditioner: RTL
====================

Name: key_conditioner

Overview:
- Front-end conditioning stage for the four active-low push-buttons. Its outputs feed the UI cooldown counters and the gate-selection logic.
- Synchronizes each raw KEY line to CLOCK_50 and debounces it with a per-key stable-time counter.
- Emits exactly one single-cycle press pulse per physical press.
- On the selection keys only, adds hold-to-repeat pulses so the gate indicator steps continuously while a key is held.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a new level must persist before it is accepted (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from the accepted press to the first repeat pulse (0.5 s); must be >= 1.
- REPEAT_RATE, 10000000, cycles between subsequent repeat pulses (0.2 s); must be >= 1.
- REPEAT_MASK, 4'b0011, per-key auto-repeat enable (default: KEY[0] next, KEY[1] back).
- CNT_W, 25, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetN  input  1  asynchronous active-low reset.
- KEY  input  4  raw buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- masterEnable  input  1  game-running qualifier; when 0, pulse outputs are suppressed.
- keyLevel  output  4  debounced state, active-high (1 = pressed).
- pressPulse  output  4  one-cycle pulse per accepted press, plus repeat pulses on REPEAT_MASK keys.
- releasePulse  output  4  one-cycle pulse per accepted release.

Behaviour:
- Reset (resetN = 0, asynchronous):
  - Both synchronizer flops = 1 (released).
  - keyLevel = 0, pressPulse = 0, releasePulse = 0.
  - All counters = 0; all repeat FSMs = IDLE.
- Synchronizer: two-flop chain per key. sync = second flop, inverted to active-high pressed.
- Debounce, per key, independent:
  - When sync != keyLevel, the counter increments each cycle.
  - When the counter == DEBOUNCE_CYCLES-1 and the mismatch is still present, keyLevel toggles and the counter clears.
  - When sync == keyLevel, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected and the counter restarts.
  - Raw edge to keyLevel change = DEBOUNCE_CYCLES+2 cycles.
- Edge pulses (registered): pressPulse/releasePulse assert for exactly 1 cycle, in the cycle after keyLevel rises/falls. Raw-to-pulse latency = DEBOUNCE_CYCLES+3.
- Repeat FSM, per key with REPEAT_MASK bit = 1. States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on an accepted press (same cycle as pressPulse); the repeat timer clears.
  - DELAY: the timer counts. At REPEAT_DELAY-1: one pressPulse cycle, timer clears, go to REPEAT.
  - REPEAT: at REPEAT_RATE-1: one pressPulse cycle, timer clears, stay in REPEAT.
  - Any state -> IDLE when keyLevel = 0 or masterEnable = 0.
  - Keys with REPEAT_MASK bit = 0 hold IDLE permanently.
- masterEnable = 0:
  - pressPulse and releasePulse are forced 0.
  - keyLevel continues tracking.
  - No pulse is queued or replayed later.
- A key already held when masterEnable rises produces no pulse until it is released and pressed again.
- Simultaneous keys are fully independent; any combination of pressPulse bits may be high in the same cycle.
- Reset mid-press: everything clears. A key still held after reset release is treated as a new press and produces pressPulse after DEBOUNCE_CYCLES+3 cycles.
- Counters saturate; they never wrap while a mismatch persists.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5, masterEnable=1 unless stated):
- KEY[2] driven low at cycle 0 and held 30 cycles, then released:
  - keyLevel[2] rises at cycle 6.
  - pressPulse[2] is high only at cycle 7.
  - Release gives releasePulse[2] exactly 7 cycles after the raw edge.
  - No repeat pulses on KEY[2].
- KEY[3] low-pulse glitches of 1, 2 and 3 cycles, spaced 10 apart -> keyLevel[3] stays 0; no pulses.
- KEY[0] held 40 cycles:
  - pressPulse[0] at cycle 7.
  - Repeat pulses at cycles 17, 22, 27, 32, 37, 42 (the 42 pulse fires because keyLevel[0] stays high until cycle 46).
  - No pulses after release.
- KEY[0] and KEY[1] pressed on the same cycle -> both pressPulse bits high at cycle 7 and both repeat in lockstep.
- masterEnable = 0 while KEY[3] is pressed and held:
  - keyLevel[3] = 1; pressPulse stays 0.
  - After masterEnable rises, still no pulse.
  - Release and re-press gives pressPulse[3] 7 cycles after the new edge.
- resetN asserted at cycle 20 while KEY[1] is held (in REPEAT):
  - All outputs clear immediately.
  - After resetN deasserts with KEY[1] still held, pressPulse[1] fires 7 cycles later.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces four active-low push-buttons,
// then turns them into registered press/release pulses. Keys selected by
// REPEAT_MASK also emit hold-to-repeat press pulses while held.
module key_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_RATE     = 10000000,
  parameter logic [3:0] REPEAT_MASK     = 4'b0011,
  parameter int         CNT_W           = 25
) (
  input  logic       CLOCK_50,
  input  logic       resetN,
  input  logic [3:0] KEY,
  input  logic       masterEnable,
  output logic [3:0] keyLevel,
  output logic [3:0] pressPulse,
  output logic [3:0] releasePulse
);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [3:0] sync_p0, sync_p1;
  logic [3:0] level_p2, level_dly_p3;
  logic [3:0] rise_p2, fall_p2, fire_p2;
  logic [3:0] press_p3, release_p3;

  // ---- stage p0/p1: two-flop synchronizer, idles at released (1) ----
  // Bring the asynchronous raw key lines into the CLOCK_50 domain.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      sync_p0 <= 4'hF;
      sync_p1 <= 4'hF;
    end else begin
      sync_p0 <= KEY;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: per-key debounce and repeat timing ----
  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [CNT_W-1:0] db_cnt;
    logic             lvl;

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLOCK_50 or negedge resetN) begin
      if (!resetN) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else if (~sync_p1[k] != lvl) begin
        if (db_cnt == DB_LAST) begin
          lvl    <= ~lvl;
          db_cnt <= '0;
        end else begin
          db_cnt <= sat_inc(db_cnt);
        end
      end else begin
        db_cnt <= '0;
      end
    end

    assign level_p2[k] = lvl;

    if (REPEAT_MASK[k]) begin : g_rpt
      rpt_state_t       state, state_next;
      logic [CNT_W-1:0] rpt_cnt, rpt_cnt_next;
      logic             fire;

      // Repeat FSM state and timer registers.
      always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
          state   <= RPT_IDLE;
          rpt_cnt <= '0;
        end else begin
          state   <= state_next;
          rpt_cnt <= rpt_cnt_next;
        end
      end

      // Arm on a fresh press, fire after the delay, then at the repeat rate.
      always_comb begin
        state_next   = state;
        rpt_cnt_next = rpt_cnt;
        fire         = 1'b0;
        if (!lvl || !masterEnable) begin
          state_next   = RPT_IDLE;
          rpt_cnt_next = '0;
        end else begin
          case (state)
            RPT_IDLE: begin
              rpt_cnt_next = '0;
              if (rise_p2[k]) state_next = RPT_DELAY;
            end
            RPT_DELAY: begin
              if (rpt_cnt == DLY_LAST) begin
                fire         = 1'b1;
                rpt_cnt_next = '0;
                state_next   = RPT_REPEAT;
              end else begin
                rpt_cnt_next = sat_inc(rpt_cnt);
              end
            end
            RPT_REPEAT: begin
              if (rpt_cnt == RATE_LAST) begin
                fire         = 1'b1;
                rpt_cnt_next = '0;
              end else begin
                rpt_cnt_next = sat_inc(rpt_cnt);
              end
            end
            default: begin
              state_next   = RPT_IDLE;
              rpt_cnt_next = '0;
            end
          endcase
        end
      end

      assign fire_p2[k] = fire;
    end else begin : g_norpt
      assign fire_p2[k] = 1'b0;
    end
  end

  assign rise_p2 = level_p2 & ~level_dly_p3;
  assign fall_p2 = ~level_p2 & level_dly_p3;

  // ---- stage p3: registered edge and repeat pulses ----
  // Delay the debounced level for edge detection and register the pulses.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      level_dly_p3 <= 4'h0;
      press_p3     <= 4'h0;
      release_p3   <= 4'h0;
    end else begin
      level_dly_p3 <= level_p2;
      press_p3     <= {4{masterEnable}} & (rise_p2 | fire_p2);
      release_p3   <= {4{masterEnable}} & fall_p2;
    end
  end

  assign keyLevel     = level_p2;
  assign pressPulse   = press_p3 & {4{masterEnable}};
  assign releasePulse = release_p3 & {4{masterEnable}};

endmodule
